output_load_sequencer: RTL and testbench

Controller that sequences the PIM output buffer after a PIM operation finishes. On a start command it optionally issues a zero-point pulse, performs the read-mode capture or waits out the processing latency, then drives load enable and load count to stream 32-bit words through a valid/ready interface. Finishes with a done pulse. Sits between the peripheral register/bus interface and the output buffer top.

---
 rtl/out_seq_pkg.sv | 24 ++
 rtl/out_seq_skid.sv | 47 ++++
 rtl/output_load_sequencer.sv | 143 ++++++++++++++
 tb/tb_output_load_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/out_seq_pkg.sv
// Shared constants and FSM state type for the output load sequencer.
package out_seq_pkg;

  localparam logic [2:0] PIM_READ     = 3'b011;
  localparam logic [2:0] PIM_PARALLEL = 3'b101;
  localparam logic [2:0] PIM_RBR      = 3'b110;

  localparam int NUM_GROUPS_C = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ZP,
    S_CAPT,
    S_WAIT,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_e;

  function automatic logic mode_legal(input logic [2:0] m);
    return (m == PIM_READ) || (m == PIM_PARALLEL) || (m == PIM_RBR);
  endfunction

endpackage

// File: rtl/out_seq_skid.sv
// Single-entry valid/ready output register; a new word may be captured while
// the held word is being consumed, so streaming runs at one word per cycle.
module out_seq_skid
  import out_seq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        capture_i,
  input  logic [31:0] data_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic        can_load_o
);

  logic        valid_d, valid_q;
  logic [31:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (capture_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign can_load_o = !valid_q || ready_i;

endmodule

// File: rtl/output_load_sequencer.sv
// Sequences the PIM output buffer: zero point, capture/latency wait, word
// streaming, done pulse. Optional stall counter under OUT_SEQ_PERF_CNT_EN.
//   state  | meaning
//   IDLE   | waiting for start
//   ZP     | one-cycle zero-point strobe
//   CAPT   | one-cycle READ-mode capture strobe
//   WAIT   | processing latency down-count
//   LOAD   | loading buffer words into the output register
//   DRAIN  | waiting for the final word to be accepted
//   DONE   | done pulse (PARALLEL/RBR only)
module output_load_sequencer
  import out_seq_pkg::*;
#(
  parameter int PROC_LAT   = 4,
  parameter int NUM_GROUPS = NUM_GROUPS_C
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  mode_i,
  input  logic [8:0]  col_addr_i,
  input  logic        zp_req_i,
  input  logic [31:0] zp_data_i,
  input  logic        abort_i,
  input  logic [31:0] buf_data_i,
  output logic [2:0]  before_load_mode_o,
  output logic        read_mode_buf_w_en_o,
  output logic [8:0]  col_addr9_o,
  output logic        load_en_o,
  output logic [4:0]  load_cnt_o,
  output logic        zp_en_o,
  output logic [31:0] zp_data_o,
  output logic        output_processing_done_o,
  output logic        out_valid_o,
  output logic [31:0] out_data_o,
  input  logic        out_ready_i,
  output logic        busy_o,
  output logic        err_o,
  output logic [15:0] stall_cnt_o
);

  state_e      state_d, state_q;
  logic [2:0]  mode_q;
  logic [8:0]  col_q;
  logic [31:0] zp_q;
  logic [4:0]  load_cnt_q;
  logic [5:0]  wcnt_q;
  logic [3:0]  wait_q;
  logic        err_q;
  logic        start_ok, abort_act, can_load;

  assign start_ok  = (state_q == S_IDLE) && start_i && mode_legal(mode_i);
  assign abort_act = abort_i && (state_q != S_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok)
                 state_d = zp_req_i ? S_ZP : ((mode_i == PIM_READ) ? S_CAPT : S_WAIT);
      S_ZP:    state_d = (mode_q == PIM_READ) ? S_CAPT : S_WAIT;
      S_CAPT:  state_d = S_LOAD;
      S_WAIT:  if (wait_q == 4'd0) state_d = S_LOAD;
      S_LOAD:  if (load_en_o && (wcnt_q == 6'd1)) state_d = S_DRAIN;
      S_DRAIN: if (!out_valid_o || out_ready_i) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_act) state_d = S_IDLE;
  end

  always_comb begin
    busy_o                   = (state_q != S_IDLE);
    zp_en_o                  = (state_q == S_ZP);
    read_mode_buf_w_en_o     = (state_q == S_CAPT);
    load_en_o                = (state_q == S_LOAD) && !abort_i && can_load;
    output_processing_done_o = (state_q == S_DONE) && (mode_q != PIM_READ);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q     <= '0;
      col_q      <= '0;
      zp_q       <= '0;
      load_cnt_q <= '0;
      wcnt_q     <= '0;
      wait_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= (state_q == S_IDLE) && start_i && !mode_legal(mode_i);
      if (start_ok) begin
        mode_q     <= mode_i;
        col_q      <= col_addr_i;
        zp_q       <= zp_data_i;
        load_cnt_q <= 5'd31;
        wcnt_q     <= (mode_i == PIM_READ) ? 6'd1 : 6'(NUM_GROUPS);
        wait_q     <= 4'(PROC_LAT - 1);
      end else begin
        if (state_q == S_WAIT && wait_q != 4'd0) wait_q <= wait_q - 4'd1;
        // load_cnt wraps 0 -> 31 naturally in 5 bits
        if (load_en_o) begin
          load_cnt_q <= load_cnt_q - 5'd1;
          wcnt_q     <= wcnt_q - 6'd1;
        end
      end
    end
  end

  out_seq_skid u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (abort_act),
    .capture_i  (load_en_o),
    .data_i     (buf_data_i),
    .ready_i    (out_ready_i),
    .valid_o    (out_valid_o),
    .data_o     (out_data_o),
    .can_load_o (can_load)
  );

  assign before_load_mode_o = mode_q;
  assign col_addr9_o        = col_q;
  assign zp_data_o          = zp_q;
  assign load_cnt_o         = load_cnt_q;
  assign err_o              = err_q;

`ifdef OUT_SEQ_PERF_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                         stall_q <= '0;
    else if (start_ok)                                 stall_q <= '0;
    else if (out_valid_o && !out_ready_i && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_output_load_sequencer.sv
// Directed bench for output_load_sequencer: PARALLEL/READ/RBR runs, stalls,
// abort, illegal mode, start while busy and asynchronous reset.
module tb_output_load_sequencer;
  import out_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, zp_req, abort, ready;
  logic [2:0]  mode;
  logic [8:0]  col;
  logic [31:0] zp_data, buf_data;
  logic [2:0]  mode_o;
  logic        rmbwe, load_en, zp_en, done, valid, busy, err;
  logic [8:0]  col_o;
  logic [4:0]  load_cnt;
  logic [31:0] zp_data_o, data;
  logic [15:0] stall;

  int total = 0;
  int bad   = 0;
  int acc;
  bit done_seen, stalled;
  logic [31:0] prev;

  always #5 clk = ~clk;

  // Buffer model: group index = 31 - load_cnt, word tagged with the index
  assign buf_data = load_en ? (32'hC0DE_0000 | {27'd0, 5'd31 - load_cnt}) : 32'hDEAD_BEEF;

  output_load_sequencer dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .col_addr_i(col),
    .zp_req_i(zp_req), .zp_data_i(zp_data), .abort_i(abort), .buf_data_i(buf_data),
    .before_load_mode_o(mode_o), .read_mode_buf_w_en_o(rmbwe), .col_addr9_o(col_o),
    .load_en_o(load_en), .load_cnt_o(load_cnt), .zp_en_o(zp_en), .zp_data_o(zp_data_o),
    .output_processing_done_o(done), .out_valid_o(valid), .out_data_o(data),
    .out_ready_i(ready), .busy_o(busy), .err_o(err), .stall_cnt_o(stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full PARALLEL/RBR run with out_ready held high; optionally pulses start mid-run.
  task automatic run_par(input logic [2:0] m, input bit inject);
    mode = m; zp_req = 1'b0; ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (inject && cyc == 10) begin start = 1'b1; mode = PIM_READ; end
      else start = 1'b0;
      chk($sformatf("par_load_en_c%0d", cyc), load_en, (cyc >= 5 && cyc <= 36));
      if (cyc >= 5 && cyc <= 36) chk($sformatf("par_load_cnt_c%0d", cyc), load_cnt, 32'(36 - cyc));
      chk($sformatf("par_valid_c%0d", cyc), valid, (cyc >= 6 && cyc <= 37));
      if (cyc >= 6 && cyc <= 37) chk($sformatf("par_data_c%0d", cyc), data, 32'hC0DE_0000 + 32'(cyc - 6));
      chk($sformatf("par_done_c%0d", cyc), done, (cyc == 38));
      chk($sformatf("par_busy_c%0d", cyc), busy, (cyc <= 38));
      step();
    end
    start = 1'b0;
    mode  = m;
    chk("par_mode_held", mode_o, m);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; zp_req = 1'b0; abort = 1'b0; ready = 1'b1;
    mode = 3'b000; col = '0; zp_data = '0;
    step(); step();
    chk("rst_busy", busy, 0);  chk("rst_valid", valid, 0); chk("rst_data", data, 0);
    chk("rst_load_en", load_en, 0); chk("rst_load_cnt", load_cnt, 0);
    chk("rst_mode", mode_o, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;
    step();

    // Illegal mode
    mode = 3'b001; start = 1'b1;
    step();
    start = 1'b0;
    chk("ill_err", err, 1); chk("ill_busy", busy, 0); chk("ill_mode", mode_o, 0);
    step();
    chk("ill_err_clr", err, 0); chk("ill_busy2", busy, 0); chk("ill_load_en", load_en, 0);

    run_par(PIM_PARALLEL, 1'b0);

    // READ with zero point
    mode = PIM_READ; col = 9'h1A5; zp_req = 1'b1; zp_data = 32'hFFFF_FF80; start = 1'b1;
    step();
    start = 1'b0; zp_req = 1'b0; col = '0; zp_data = '0;
    chk("rd_zp_en", zp_en, 1); chk("rd_zp_data", zp_data_o, 32'hFFFF_FF80);
    chk("rd_mode", mode_o, PIM_READ); chk("rd_rmbwe0", rmbwe, 0);
    step();
    chk("rd_zp_en_clr", zp_en, 0); chk("rd_rmbwe", rmbwe, 1); chk("rd_col", col_o, 9'h1A5);
    step();
    chk("rd_load_en", load_en, 1); chk("rd_load_cnt", load_cnt, 31); chk("rd_valid0", valid, 0);
    step();
    chk("rd_load_en_clr", load_en, 0); chk("rd_valid", valid, 1); chk("rd_data", data, 32'hC0DE_0000);
    step();
    chk("rd_valid_clr", valid, 0); chk("rd_done_none", done, 0); chk("rd_busy_done", busy, 1);
    step();
    chk("rd_busy_end", busy, 0); chk("rd_done_none2", done, 0); chk("rd_load_en_end", load_en, 0);

    // RBR with ready pattern 1,0,0,1
    mode = PIM_RBR; ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && !valid; i++) step();
    chk("rbr_first_valid", valid, 1);
    acc = 0; done_seen = 1'b0; stalled = 1'b0; prev = '0;
    for (int p = 0; p < 80 && !done_seen; p++) begin
      ready = ((p % 4) == 0) || ((p % 4) == 3);
      if (stalled) begin
        chk($sformatf("rbr_hold_valid_p%0d", p), valid, 1);
        chk($sformatf("rbr_hold_data_p%0d", p), data, prev);
      end
      if (valid && ready) begin
        chk($sformatf("rbr_word%0d", acc), data, 32'hC0DE_0000 + 32'(acc));
        acc++;
      end
      stalled = valid && !ready;
      prev = data;
      step();
      if (done) done_seen = 1'b1;
`ifdef OUT_SEQ_PERF_CNT_EN
      if (p == 31) chk("rbr_stall_8pat", stall, 16);
`else
      if (p == 31) chk("rbr_stall_8pat", stall, 0);
`endif
    end
    ready = 1'b1;
    chk("rbr_words", acc, 32); chk("rbr_done", done_seen, 1); chk("rbr_valid_end", valid, 0);
`ifdef OUT_SEQ_PERF_CNT_EN
    chk("rbr_stall_total", stall, 32);
`else
    chk("rbr_stall_total", stall, 0);
`endif
    step();

    // Abort during word 10
    mode = PIM_PARALLEL; ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 16; i++) step();
    chk("ab_word10", data, 32'hC0DE_000A); chk("ab_valid", valid, 1);
    abort = 1'b1;
    #1;
    chk("ab_load_en_gated", load_en, 0);
    step();
    abort = 1'b0;
    chk("ab_busy", busy, 0); chk("ab_valid_clr", valid, 0); chk("ab_mode", mode_o, PIM_PARALLEL);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ab_no_done%0d", i), done, 0);
      step();
    end
    run_par(PIM_PARALLEL, 1'b0);

    // Start while busy is ignored
    run_par(PIM_RBR, 1'b1);

    // Asynchronous reset mid-LOAD
    mode = PIM_PARALLEL; zp_data = 32'h1234_5678; col = 9'h0FF; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 10; i++) step();
    chk("mr_in_load", load_en, 1);
    rst = 1'b1;
    #1;
    chk("mr_busy", busy, 0); chk("mr_load_en", load_en, 0); chk("mr_load_cnt", load_cnt, 0);
    chk("mr_valid", valid, 0); chk("mr_data", data, 0); chk("mr_mode", mode_o, 0);
    chk("mr_zp_data", zp_data_o, 0); chk("mr_col", col_o, 0); chk("mr_done", done, 0);
    step(); step();
    rst = 1'b0;
    step();
    chk("mr_idle_busy", busy, 0); chk("mr_idle_load_en", load_en, 0);
    run_par(PIM_PARALLEL, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
